// File: rtl/alu_issue_arbiter.sv
// Round-robin issue of two requesters onto one shared combinational ALU.
// Holds the response until the consumer takes it, and owns the NZCV register.
module alu_issue_arbiter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [3:0]   req0_cmd,
   input  logic [W-1:0] req0_val1,
   input  logic [W-1:0] req0_val2,
   input  logic         req0_s,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [3:0]   req1_cmd,
   input  logic [W-1:0] req1_val1,
   input  logic [W-1:0] req1_val2,
   input  logic         req1_s,
   output logic [3:0]   alu_cmd,
   output logic [W-1:0] alu_val1,
   output logic [W-1:0] alu_val2,
   output logic         alu_c,
   input  logic [W-1:0] alu_out,
   input  logic [1:0]   alu_cv,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [W-1:0] rsp_data,
   output logic [3:0]   status
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t state, state_nxt;
   logic   last_grant;
   logic   iss_s;
   logic   iss_id;
   logic   win;
   logic   can_accept;
   logic   accept;

   // A tie goes to whichever port was not granted last; a lone requester always wins.
   always_comb begin
      win        = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
      can_accept = !rst && ((state == IDLE) || ((state == RESP) && rsp_ready));
      req0_ready = can_accept && req0_valid && !win;
      req1_ready = can_accept && req1_valid && win;
      accept     = req0_ready || req1_ready;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = BUSY;
         BUSY:    state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = accept ? BUSY : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         iss_s      <= 1'b0;
         iss_id     <= 1'b0;
         alu_cmd    <= '0;
         alu_val1   <= '0;
         alu_val2   <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_data   <= '0;
         status     <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            last_grant <= win;
            iss_id     <= win;
            iss_s      <= win ? req1_s    : req0_s;
            alu_cmd    <= win ? req1_cmd  : req0_cmd;
            alu_val1   <= win ? req1_val1 : req0_val1;
            alu_val2   <= win ? req1_val2 : req0_val2;
         end
         // The ALU result is only meaningful in the single BUSY cycle.
         if (state == BUSY) begin
            rsp_valid <= 1'b1;
            rsp_id    <= iss_id;
            rsp_data  <= alu_out;
            if (iss_s)
               status <= {alu_out[W-1], (alu_out == '0), alu_cv};
         end else if ((state == RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

   assign alu_c = status[1];

endmodule

// File: doc/alu_issue_arbiter.md
# alu_issue_arbiter

Shares the single combinational execute-stage ALU between two requesters, e.g. the instruction pipeline and a multi-cycle helper unit. Each request is accepted with a valid/ready handshake and selected round-robin. The block registers the operands into the ALU, captures the result and the ALU flags into a held response, and owns the NZCV status register, which also supplies the carry input to the ALU.

## Interface
Parameters:
- W, 32, operand/result width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle when high with req0_valid
- req0_cmd  in  4  ALU command code (team ALU encoding: MOV 0001, MVN 1001, ADD/LDR/STR 0010, ADC 0011, SUB/CMP 0100, SBC 0101, AND/TST 0110, ORR 0111, EOR 1000)
- req0_val1, req0_val2  in  W  operands
- req0_s  in  1  update status register with this result
- req1_valid, req1_ready, req1_cmd, req1_val1, req1_val2, req1_s: same as port 0, for requester 1
- alu_cmd  out  4  command to ALU
- alu_val1, alu_val2  out  W  operands to ALU
- alu_c  out  1  carry-in to ALU (status C)
- alu_out  in  W  ALU result (combinational from alu_* outputs)
- alu_cv  in  2  {carry, overflow} produced by ALU for the current command
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  requester index of response
- rsp_data  out  W  captured result
- status  out  4  NZCV status register {N,Z,C,V}

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: req_ready offered to the arbitration winner only.
  - On handshake: latch cmd/val1/val2/s/id into the issue register, then go to BUSY.
- BUSY: the issue register drives alu_cmd/alu_val1/alu_val2. alu_c = status[1].
  - At the end of the cycle: rsp_data <= alu_out, rsp_id <= id, rsp_valid <= 1, then go to RESP.
  - If s=1, the status register is updated on the same edge: N=alu_out[W-1], Z=(alu_out==0), C=alu_cv[1], V=alu_cv[0].
  - If s=0, status is unchanged.
- RESP: rsp_* held stable until rsp_ready=1.
  - If rsp_ready=1 and no request is accepted this cycle: rsp_valid <= 0, then go to IDLE.
  - If rsp_ready=1, a new request may be accepted in the same cycle (req_ready offered to the winner), then go directly to BUSY.
  - If rsp_ready=0: no req_ready, stay in RESP.
- Arbitration, round-robin:
  - last_grant bit holds the requester granted most recently.
  - If both requesters are valid, the one not equal to last_grant wins.
  - If one requester is valid, it wins.
  - last_grant updates on each accept.
- The loser sees req_ready=0 and must hold its request. The block stores no pending requests.
- Outside BUSY, alu_cmd/alu_val1/alu_val2 keep the last issued values. The ALU result is ignored then.
- No arithmetic is done in this block beyond the N and Z derivation; width W is used throughout.

## Timing
- Reset values:
  - state IDLE, last_grant=1 (port 0 wins first tie)
  - rsp_valid=0, rsp_id=0, rsp_data=0, status=0000
  - issue register cleared: alu_cmd=0000, alu_val1=alu_val2=0, alu_c=0
  - req0_ready=req1_ready=0 during the reset cycle
- req_ready is combinational from state, rsp_ready and the valid inputs. It is never high for both ports at once.
- Latency: handshake at edge k → ALU driven in cycle k..k+1 → rsp_valid=1 from edge k+1.
  - Result visible one cycle after accept with rsp_ready held high.
  - Sustained throughput: one op per 2 cycles.
- Flags written by operation n are seen as alu_c by operation n+1. There is no forwarding hazard, because issue of n+1 follows capture of n.
- Reset asserted in any state: the in-flight operation is discarded. There is no response, all state returns to reset values next edge, and status is not updated.

## Test plan
- Single op: req0 ADD(0010) 5,7 s=0, rsp_ready=1 → req0_ready=1 in cycle 0; rsp_valid, rsp_id=0, rsp_data=12 one cycle later; status stays 0000.
- Tie after reset: req0 MOV 0x11 and req1 MVN 0 both held valid → grants alternate 0,1,0,1; responses 0x11 (id0), 0xFFFFFFFF (id1) in order; never both ready.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → rsp_data/rsp_id stable, no req_ready; on rsp_ready=1 a waiting req1 is accepted in the same cycle.
- Flags/carry: SUB 3,3 s=1 with alu_cv=10 → status=0110. Next ADC 1,1 → alu_c=1 while it is driven. Then s=0 op → status unchanged.
- Negative result: SUB 1,2 s=1, alu_cv=00 → status=1000, rsp_data=0xFFFFFFFF.
- Reset mid-op: rst=1 during BUSY of an s=1 op → no rsp_valid, status=0000, next tie granted to port 0.
